// File: rtl/tft_power_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tft_power_sequencer_pkg
// Shared definitions for the TFT panel power sequencer:
//   - tft_state_t : FSM state encoding (also the value on the debug 'state' port)
//   - DEF_*       : default timing constants for a 480x272 panel
//   - tft_out_t   : the registered enable bundle driven to the panel
//   - state_outputs() : enable bundle that belongs to each state
//   - is_watched()    : states in which the raster is expected to deliver frames
// -----------------------------------------------------------------------------
package tft_power_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_VDD_UP    = 3'd1,
      ST_DISP_WAIT = 3'd2,
      ST_RUN       = 3'd3,
      ST_BL_DOWN   = 3'd4,
      ST_DISP_DOWN = 3'd5,
      ST_OFF_HOLD  = 3'd6,
      ST_FAULT     = 3'd7
   } tft_state_t;

   localparam int DEF_VDD_TO_DISP_CYC   = 4500;
   localparam int DEF_FRAMES_TO_BL      = 2;
   localparam int DEF_FRAMES_BL_OFF     = 1;
   localparam int DEF_DISP_TO_VDD_CYC   = 4500;
   localparam int DEF_OFF_MIN_CYC       = 90000;
   localparam int DEF_FRAME_TIMEOUT_CYC = 200000;
   localparam int DEF_CNT_W             = 24;

   // Frame counter width; the count saturates, so frame thresholds above
   // 2**FRM_W are not meaningful.
   localparam int FRM_W = 8;

   typedef struct packed {
      logic vdd;
      logic display;   // also drives raster_run
      logic bl;        // also drives ready
      logic fault;
   } tft_out_t;

   function automatic tft_out_t state_outputs(input tft_state_t s);
      tft_out_t o;
      o = '0;
      case (s)
         ST_VDD_UP:    o.vdd = 1'b1;
         ST_DISP_WAIT: begin o.vdd = 1'b1; o.display = 1'b1; end
         ST_RUN:       begin o.vdd = 1'b1; o.display = 1'b1; o.bl = 1'b1; end
         ST_BL_DOWN:   begin o.vdd = 1'b1; o.display = 1'b1; end
         ST_DISP_DOWN: o.vdd = 1'b1;
         ST_FAULT:     o.fault = 1'b1;
         default:      o = '0;
      endcase
      return o;
   endfunction

   function automatic logic is_watched(input tft_state_t s);
      return (s == ST_DISP_WAIT) || (s == ST_RUN) || (s == ST_BL_DOWN);
   endfunction

endpackage

// File: rtl/tft_power_sequencer_timer.sv
// -----------------------------------------------------------------------------
// tft_power_sequencer_timer
// Load/decrement down-counter used for the state delays and the frame
// watchdog. i_load has priority and copies i_load_val into the counter; the
// counter then decrements once per cycle and stops at zero (no wrap).
// o_done is high while the count is zero, so a load of N-1 gives a done
// indication in the N-th cycle after the load edge.
// Ports:
//   tft_clk    in          clock
//   rstb       in          synchronous active-low reset (count -> 0)
//   i_load     in          load strobe
//   i_load_val in  CNT_W   value loaded on i_load
//   o_done     out         count is zero
// -----------------------------------------------------------------------------
module tft_power_sequencer_timer #(
   parameter int CNT_W = 24
) (
   input  logic             tft_clk,
   input  logic             rstb,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge tft_clk) begin
      if (!rstb) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - L_ONE;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/tft_power_sequencer.sv
// -----------------------------------------------------------------------------
// tft_power_sequencer
// Power/enable controller for the 480x272 TFT datapath. Brings the panel up
// as vdd -> display -> backlight and down in the reverse order, gates the
// raster counter and the backlight PWM, and watches the raster's new_frame
// pulse: if frames stop while the raster should be running, everything is
// dropped at once and a sticky fault is raised until power_req is released.
//
// Interface protocol (no valid/ready handshake in this block):
//   power_req is a level, sampled every cycle; new_frame is a single-cycle
//   pulse and is only acted on in DISP_WAIT, RUN and BL_DOWN. All outputs are
//   registered and change on the same edge as 'state'.
//
// Ports:
//   tft_clk     in      pixel clock
//   rstb        in      synchronous active-low reset
//   power_req   in      1 = panel wanted on
//   new_frame   in      end-of-frame pulse from raster
//   tft_vdd     out     panel supply enable
//   tft_display out     panel DISP enable
//   raster_run  out     raster counter enable (same as tft_display)
//   bl_enable   out     backlight PWM gate
//   ready       out     high only in RUN
//   fault       out     frame-timeout flag, held in FAULT
//   state       out 3   current FSM state (debug)
// -----------------------------------------------------------------------------
module tft_power_sequencer
   import tft_power_sequencer_pkg::*;
#(
   parameter int VDD_TO_DISP_CYC   = DEF_VDD_TO_DISP_CYC,
   parameter int FRAMES_TO_BL      = DEF_FRAMES_TO_BL,
   parameter int FRAMES_BL_OFF     = DEF_FRAMES_BL_OFF,
   parameter int DISP_TO_VDD_CYC   = DEF_DISP_TO_VDD_CYC,
   parameter int OFF_MIN_CYC       = DEF_OFF_MIN_CYC,
   parameter int FRAME_TIMEOUT_CYC = DEF_FRAME_TIMEOUT_CYC,
   parameter int CNT_W             = DEF_CNT_W
) (
   input  logic       tft_clk,
   input  logic       rstb,
   input  logic       power_req,
   input  logic       new_frame,
   output logic       tft_vdd,
   output logic       tft_display,
   output logic       raster_run,
   output logic       bl_enable,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state
);

   // Timers are loaded with N-1 so that a state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] L_VDD_TO_DISP = CNT_W'(VDD_TO_DISP_CYC - 1);
   localparam logic [CNT_W-1:0] L_DISP_TO_VDD = CNT_W'(DISP_TO_VDD_CYC - 1);
   localparam logic [CNT_W-1:0] L_OFF_MIN     = CNT_W'(OFF_MIN_CYC - 1);
   localparam logic [CNT_W-1:0] L_TIMEOUT     = CNT_W'(FRAME_TIMEOUT_CYC - 1);
   // r_frames holds the pulses already seen in the state, so the threshold
   // pulse is the one arriving when r_frames equals target-1.
   localparam logic [FRM_W-1:0] L_FR_TO_BL    = FRM_W'(FRAMES_TO_BL - 1);
   localparam logic [FRM_W-1:0] L_FR_BL_OFF   = FRM_W'(FRAMES_BL_OFF - 1);
   localparam logic [FRM_W-1:0] L_FRM_ONE     = FRM_W'(1);

   tft_state_t       r_state;
   tft_state_t       w_next;
   tft_out_t         r_out;
   tft_out_t         w_out;
   logic [FRM_W-1:0] r_frames;

   logic             w_state_change;
   logic             w_frame_in;
   logic             w_dly_load;
   logic [CNT_W-1:0] w_dly_val;
   logic             w_dly_done;
   logic             w_wd_load;
   logic             w_wd_done;
   logic             w_wd_timeout;

   assign w_state_change = (w_next != r_state);
   assign w_frame_in     = new_frame && is_watched(r_state);
   // A new_frame in the timeout cycle counts as a live raster.
   assign w_wd_timeout   = is_watched(r_state) && w_wd_done && !new_frame;

   // State delay timer: reloaded on every state entry with that state's delay.
   assign w_dly_load = w_state_change;
   always_comb begin
      w_dly_val = '0;
      case (w_next)
         ST_VDD_UP:    w_dly_val = L_VDD_TO_DISP;
         ST_DISP_DOWN: w_dly_val = L_DISP_TO_VDD;
         ST_OFF_HOLD:  w_dly_val = L_OFF_MIN;
         default:      w_dly_val = '0;
      endcase
   end

   // Frame watchdog: restarted on entry to any watched state and on every
   // accepted new_frame.
   assign w_wd_load = (w_state_change && is_watched(w_next)) || w_frame_in;

   tft_power_sequencer_timer #(.CNT_W(CNT_W)) u_dly_timer (
      .tft_clk    (tft_clk),
      .rstb       (rstb),
      .i_load     (w_dly_load),
      .i_load_val (w_dly_val),
      .o_done     (w_dly_done)
   );

   tft_power_sequencer_timer #(.CNT_W(CNT_W)) u_wd_timer (
      .tft_clk    (tft_clk),
      .rstb       (rstb),
      .i_load     (w_wd_load),
      .i_load_val (L_TIMEOUT),
      .o_done     (w_wd_done)
   );

   always_ff @(posedge tft_clk) begin
      if (!rstb) begin
         r_state <= ST_OFF;
      end else begin
         r_state <= w_next;
      end
   end

   // Watchdog expiry outranks everything else in the watched states; in
   // DISP_WAIT a dropped power_req outranks a same-cycle frame.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_OFF: begin
            if (power_req) w_next = ST_VDD_UP;
         end
         ST_VDD_UP: begin
            if (!power_req)      w_next = ST_DISP_DOWN;
            else if (w_dly_done) w_next = ST_DISP_WAIT;
         end
         ST_DISP_WAIT: begin
            if (w_wd_timeout)    w_next = ST_FAULT;
            else if (!power_req) w_next = ST_DISP_DOWN;
            else if (new_frame && (r_frames >= L_FR_TO_BL)) w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_wd_timeout)    w_next = ST_FAULT;
            else if (!power_req) w_next = ST_BL_DOWN;
         end
         ST_BL_DOWN: begin
            // power_req is deliberately ignored: shutdown always completes.
            if (w_wd_timeout) w_next = ST_FAULT;
            else if (new_frame && (r_frames >= L_FR_BL_OFF)) w_next = ST_DISP_DOWN;
         end
         ST_DISP_DOWN: begin
            if (w_dly_done) w_next = ST_OFF_HOLD;
         end
         ST_OFF_HOLD: begin
            if (w_dly_done) w_next = ST_OFF;
         end
         ST_FAULT: begin
            if (!power_req) w_next = ST_OFF_HOLD;
         end
         default: w_next = ST_OFF;
      endcase
   end

   // Frame count restarts on every state change and saturates.
   always_ff @(posedge tft_clk) begin
      if (!rstb) begin
         r_frames <= '0;
      end else if (w_state_change) begin
         r_frames <= '0;
      end else if (w_frame_in && (r_frames != '1)) begin
         r_frames <= r_frames + L_FRM_ONE;
      end
   end

   // Outputs are decoded from the next state so they line up with 'state'.
   assign w_out = state_outputs(w_next);

   always_ff @(posedge tft_clk) begin
      if (!rstb) begin
         r_out <= '0;
      end else begin
         r_out <= w_out;
      end
   end

   assign tft_vdd     = r_out.vdd;
   assign tft_display = r_out.display;
   assign raster_run  = r_out.display;
   assign bl_enable   = r_out.bl;
   assign ready       = r_out.bl;
   assign fault       = r_out.fault;
   assign state       = r_state;

endmodule

// File: tb/tb_tft_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tft_power_sequencer
// Directed bench for the TFT power sequencer. The driver issues power_req /
// new_frame spans and pushes each expected output change as
// {cycle, state, fault, ready, bl_enable, raster_run, tft_display, tft_vdd}.
// The monitor samples on the falling edge, pops an entry whenever the output
// vector changes and compares cycle and value; it also checks that all
// outputs are zero in every cycle following a reset edge.
// -----------------------------------------------------------------------------
module tb_tft_power_sequencer;

   localparam int EW = 25;

   logic       tft_clk = 1'b0;
   logic       rstb;
   logic       power_req;
   logic       new_frame;
   logic       tft_vdd;
   logic       tft_display;
   logic       raster_run;
   logic       bl_enable;
   logic       ready;
   logic       fault;
   logic [2:0] state;

   int             cyc = 0;
   logic           rst_at_edge = 1'b0;
   logic           drv_done = 1'b0;
   int             checks = 0;
   int             failures = 0;
   logic [EW-1:0]  exp_q[$];
   logic [8:0]     cur;
   logic [8:0]     prev = '0;
   logic [EW-1:0]  got_e;
   logic [EW-1:0]  want_e;

   // ---------------- clock / reset bookkeeping ----------------
   always #5 tft_clk = ~tft_clk;

   always @(posedge tft_clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= !rstb;
   end

   tft_power_sequencer #(
      .VDD_TO_DISP_CYC   (4),
      .FRAMES_TO_BL      (2),
      .FRAMES_BL_OFF     (1),
      .DISP_TO_VDD_CYC   (3),
      .OFF_MIN_CYC       (5),
      .FRAME_TIMEOUT_CYC (20),
      .CNT_W             (24)
   ) dut (
      .tft_clk     (tft_clk),
      .rstb        (rstb),
      .power_req   (power_req),
      .new_frame   (new_frame),
      .tft_vdd     (tft_vdd),
      .tft_display (tft_display),
      .raster_run  (raster_run),
      .bl_enable   (bl_enable),
      .ready       (ready),
      .fault       (fault),
      .state       (state)
   );

   // Expected output vector for each state, straight from the state table.
   function automatic logic [8:0] exp_vec(input logic [2:0] s);
      logic [8:0] v;
      case (s)
         3'd0:    v = {3'd0, 6'b000000};
         3'd1:    v = {3'd1, 6'b000001};
         3'd2:    v = {3'd2, 6'b000111};
         3'd3:    v = {3'd3, 6'b011111};
         3'd4:    v = {3'd4, 6'b000111};
         3'd5:    v = {3'd5, 6'b000001};
         3'd6:    v = {3'd6, 6'b000000};
         default: v = {3'd7, 6'b100000};
      endcase
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push(input int c, input logic [2:0] s);
      exp_q.push_back({16'(c), exp_vec(s)});
   endtask

   // n cycles at power_req=pr; a one-cycle frame pulse on every period-th
   // cycle of the span (period 0 = no frames).
   task automatic span(input logic pr, input int n, input int period);
      for (int k = 0; k < n; k++) begin
         @(posedge tft_clk);
         #1;
         power_req = pr;
         new_frame = (period > 0) && ((k % period) == (period - 1));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b;
      rstb      = 1'b0;
      power_req = 1'b1;
      new_frame = 1'b0;

      // Reset held with power_req high: everything stays 0.
      for (int i = 0; i < 6; i++) begin
         @(posedge tft_clk);
         #1;
      end
      @(posedge tft_clk);
      #1;
      rstb      = 1'b1;
      power_req = 1'b0;

      // Power-up: vdd +1, display +5, backlight on the 2nd frame.
      b = cyc + 1;
      push(b + 1,  3'd1);
      push(b + 5,  3'd2);
      push(b + 20, 3'd3);
      span(1'b1, 25, 10);

      // Power-down from RUN, re-request during OFF_HOLD, then an early
      // drop during VDD_UP.
      b = cyc + 1;
      push(b + 1,  3'd4);
      push(b + 10, 3'd5);
      push(b + 13, 3'd6);
      push(b + 18, 3'd0);
      push(b + 19, 3'd1);
      push(b + 21, 3'd5);
      push(b + 24, 3'd6);
      push(b + 29, 3'd0);
      span(1'b0, 14, 10);
      span(1'b1, 6, 0);
      span(1'b0, 12, 0);

      // Frames stop in RUN: FAULT 21 cycles after the last pulse, cleared
      // through OFF_HOLD once power_req drops.
      b = cyc + 1;
      push(b + 1,  3'd1);
      push(b + 5,  3'd2);
      push(b + 20, 3'd3);
      push(b + 40, 3'd7);
      span(1'b1, 20, 10);
      span(1'b1, 25, 0);
      b = cyc + 1;
      push(b + 1, 3'd6);
      push(b + 6, 3'd0);
      span(1'b0, 10, 0);

      // Frames landing exactly on the timeout cycle keep the watchdog quiet;
      // the second one coincides with power_req=0 in DISP_WAIT.
      b = cyc + 1;
      push(b + 1,  3'd1);
      push(b + 5,  3'd2);
      push(b + 45, 3'd5);
      push(b + 48, 3'd6);
      push(b + 53, 3'd0);
      span(1'b1, 5, 0);
      span(1'b1, 20, 20);
      span(1'b1, 19, 0);
      span(1'b0, 1, 1);
      span(1'b0, 12, 0);

      // Reset mid-sequence drops everything in one cycle.
      b = cyc + 1;
      push(b + 1,  3'd1);
      push(b + 5,  3'd2);
      push(b + 11, 3'd0);
      span(1'b1, 10, 0);
      @(posedge tft_clk);
      #1;
      rstb = 1'b0;
      @(posedge tft_clk);
      #1;
      @(posedge tft_clk);
      #1;
      rstb      = 1'b1;
      power_req = 1'b0;
      span(1'b0, 5, 0);

      drv_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge tft_clk) begin
      cur = {state, fault, ready, bl_enable, raster_run, tft_display, tft_vdd};

      if (rst_at_edge) begin
         checks++;
         if (cur !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got=%b want=000000000", cyc, cur);
         end
      end

      if (cur !== prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got_state=%0d got_out=%b want=no change",
                     cyc, cur[8:6], cur);
         end else begin
            want_e = exp_q.pop_front();
            got_e  = {16'(cyc), cur};
            if (got_e !== want_e) begin
               failures++;
               $display("FAIL transition got_cyc=%0d got_state=%0d got_out=%b want_cyc=%0d want_state=%0d want_out=%b",
                        cyc, cur[8:6], cur, want_e[24:9], want_e[8:6], want_e[8:0]);
            end
         end
      end
      prev = cur;

      if (drv_done) begin
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_transitions pending=%0d next_want_cyc=%0d next_want_state=%0d",
                     exp_q.size(), exp_q[0][24:9], exp_q[0][8:6]);
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout cyc=%0d want=bench complete", cyc);
      $fatal(1);
   end

endmodule
